// File: rtl/pe_acc_pkg.sv
// Shared widths, FSM states and saturation limits for the PE accumulation stage.
// Optional PE_ACC_SAT_EN build switch (used in pe_acc_csa3/pe_acc_stage) selects clamping on overflow.
package pe_acc_pkg;

   localparam int IN_W  = 109;
   localparam int GUARD = 7;
   localparam int ACC_W = IN_W + GUARD;
   localparam int CNT_W = 8;

   localparam int MODE_FP_BIT = 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [ACC_W-1:0] ACC_SMAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_SMIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] ACC_UMAX = '1;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   // FP-mantissa operands are magnitudes, so they must not be sign-extended
   function automatic logic [ACC_W-1:0] extIn(input logic [IN_W-1:0] x, input logic isUnsigned);
      return isUnsigned ? {{GUARD{1'b0}}, x} : {{GUARD{x[IN_W-1]}}, x};
   endfunction

endpackage

// File: rtl/pe_acc_csa3.sv
// 3:2 compressor plus carry-propagate adder over ACC_W with overflow detection.
// With PE_ACC_SAT_EN defined the result is clamped to the signed/unsigned range on overflow.
module pe_acc_csa3
   import pe_acc_pkg::*;
(
   input  logic [ACC_W-1:0] i_a,
   input  logic [ACC_W-1:0] i_b,
   input  logic [ACC_W-1:0] i_c,
   input  logic             i_unsigned,
   output logic [ACC_W-1:0] o_sum,
   output logic             o_ovf
);

   localparam int WW = ACC_W + 2;

   logic [WW-1:0] w_a, w_b, w_c, w_s, w_cy, w_res;

   // Two extra bits hold the exact three-operand result, so overflow is a range test on the top bits
   assign w_a   = i_unsigned ? {2'b00, i_a} : {{2{i_a[ACC_W-1]}}, i_a};
   assign w_b   = i_unsigned ? {2'b00, i_b} : {{2{i_b[ACC_W-1]}}, i_b};
   assign w_c   = i_unsigned ? {2'b00, i_c} : {{2{i_c[ACC_W-1]}}, i_c};
   assign w_s   = w_a ^ w_b ^ w_c;
   assign w_cy  = ((w_a & w_b) | (w_a & w_c) | (w_b & w_c)) << 1;
   assign w_res = w_s + w_cy;

   assign o_ovf = i_unsigned ? (w_res[WW-1:ACC_W] != 2'b00)
                             : !((w_res[WW-1:ACC_W-1] == 3'b000) || (w_res[WW-1:ACC_W-1] == 3'b111));

`ifdef PE_ACC_SAT_EN
   always_comb begin
      o_sum = w_res[ACC_W-1:0];
      if (o_ovf) begin
         o_sum = i_unsigned ? ACC_UMAX : (w_res[WW-1] ? ACC_SMIN : ACC_SMAX);
      end
   end
`else
   assign o_sum = w_res[ACC_W-1:0];
`endif

endmodule

// File: rtl/pe_acc_stage.sv
// Burst accumulator behind the PE adder tree with a single-entry valid/ready result buffer.
// Build switch PE_ACC_SAT_EN: clamp and hold the accumulator on overflow instead of wrapping.
module pe_acc_stage
   import pe_acc_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [IN_W-1:0]  i_in_sum,
   input  logic [IN_W-1:0]  i_in_carry,
   input  logic             i_in_first,
   input  logic             i_in_last,
   input  logic [1:0]       i_in_mode,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [ACC_W-1:0] o_out_data,
   output logic [CNT_W-1:0] o_out_count,
   output logic             o_out_ovf,
   output logic             o_out_err
);

   state_t r_state, w_stateNext;

   logic [ACC_W-1:0] r_acc, w_accIn, w_accNext, w_addRes, w_sumExt, w_carryExt;
   logic [CNT_W-1:0] r_cnt, w_cntNext;
   logic [1:0]       r_mode, w_modeUse;
   logic             r_ovf, r_err, w_ovfNext, w_errNext, w_addOvf;
   logic             w_xfer, w_pop, w_start, w_unsigned;

   logic             r_outValid, r_outOvf, r_outErr;
   logic [ACC_W-1:0] r_outData;
   logic [CNT_W-1:0] r_outCount;

   assign o_in_ready = ~r_outValid | i_out_ready;
   assign w_xfer     = i_in_valid & o_in_ready;
   assign w_pop      = r_outValid & i_out_ready;

   // Any beat seen in IDLE, or a first beat anywhere, begins a fresh accumulation
   assign w_start    = (r_state == IDLE) | i_in_first;
   assign w_modeUse  = w_start ? i_in_mode : r_mode;
   assign w_unsigned = w_modeUse[MODE_FP_BIT];
   assign w_accIn    = w_start ? '0 : r_acc;
   assign w_sumExt   = extIn(i_in_sum, w_unsigned);
   assign w_carryExt = extIn(i_in_carry, w_unsigned);

   pe_acc_csa3 u_csa3 (
      .i_a        (w_accIn),
      .i_b        (w_sumExt),
      .i_c        (w_carryExt),
      .i_unsigned (w_unsigned),
      .o_sum      (w_addRes),
      .o_ovf      (w_addOvf)
   );

`ifdef PE_ACC_SAT_EN
   logic r_satLock;

   assign w_accNext = (!w_start && r_satLock) ? r_acc : w_addRes;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_satLock <= 1'b0;
      end else if (w_xfer) begin
         r_satLock <= w_start ? w_addOvf : (r_satLock | w_addOvf);
      end
   end
`else
   assign w_accNext = w_addRes;
`endif

   assign w_cntNext = w_start ? CNT_W'(1) : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1);
   assign w_ovfNext = (w_start ? 1'b0 : r_ovf) | w_addOvf;
   // Restart from ACC or a headless burst from IDLE are both protocol errors
   assign w_errNext = w_start ? ((r_state == ACC) | ~i_in_first)
                              : (r_err | (i_in_mode != r_mode));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      if (w_xfer) begin
         w_stateNext = i_in_last ? IDLE : ACC;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
         r_err  <= 1'b0;
         r_mode <= '0;
      end else if (w_xfer) begin
         r_acc  <= w_accNext;
         r_cnt  <= w_cntNext;
         r_ovf  <= w_ovfNext;
         r_err  <= w_errNext;
         r_mode <= w_modeUse;
      end
   end

   // Refill wins over pop so a result can leave and the next arrive on the same edge
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outCount <= '0;
         r_outOvf   <= 1'b0;
         r_outErr   <= 1'b0;
      end else if (w_xfer && i_in_last) begin
         r_outValid <= 1'b1;
         r_outData  <= w_accNext;
         r_outCount <= w_cntNext;
         r_outOvf   <= w_ovfNext;
         r_outErr   <= w_errNext;
      end else if (w_pop) begin
         r_outValid <= 1'b0;
      end
   end

   assign o_out_valid = r_outValid;
   assign o_out_data  = r_outData;
   assign o_out_count = r_outCount;
   assign o_out_ovf   = r_outOvf;
   assign o_out_err   = r_outErr;

endmodule

// File: tb/tb_pe_acc_stage.sv
// Randomized self-checking bench for pe_acc_stage against an arithmetic burst model.
// Honours PE_ACC_SAT_EN in its reference model when the design is built with it.
module tb_pe_acc_stage;
   import pe_acc_pkg::*;

   localparam logic [127:0] SMAX = (128'd1 << 115) - 128'd1;
   localparam logic [127:0] SMIN = ~SMAX;
   localparam logic [127:0] UMAX = (128'd1 << 116) - 128'd1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             inValid = 1'b0, inFirst = 1'b0, inLast = 1'b0, outReady = 1'b0;
   logic [IN_W-1:0]  inSum = '0, inCarry = '0;
   logic [1:0]       inMode = '0;
   logic             inReady, outValid, outOvf, outErr;
   logic [ACC_W-1:0] outData;
   logic [CNT_W-1:0] outCount;

   int checkCount = 0;
   int passCount  = 0;

   // Reference model state: the running burst and the expected result buffer
   bit               mActive, mLock, mOvf, mErr;
   logic [1:0]       mMode;
   logic [ACC_W-1:0] mAcc;
   int               mCnt;
   bit               expValid, expOvf, expErr;
   logic [ACC_W-1:0] expData;
   int               expCount;

   pe_acc_stage dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (inValid),
      .o_in_ready  (inReady),
      .i_in_sum    (inSum),
      .i_in_carry  (inCarry),
      .i_in_first  (inFirst),
      .i_in_last   (inLast),
      .i_in_mode   (inMode),
      .o_out_valid (outValid),
      .i_out_ready (outReady),
      .o_out_data  (outData),
      .o_out_count (outCount),
      .o_out_ovf   (outOvf),
      .o_out_err   (outErr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [127:0] widen(input logic [127:0] x, input int w, input bit isUnsigned);
      logic [127:0] r;
      r = x;
      if (!isUnsigned && x[w-1]) begin
         for (int k = w; k < 128; k++) r[k] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [IN_W-1:0] rand109();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[IN_W-1:0];
   endfunction

   task automatic modelBeat(input logic [IN_W-1:0] s, input logic [IN_W-1:0] c,
                            input bit f, input bit l, input logic [1:0] md);
      logic signed [127:0] total;
      bit isUns, over;
      if (!mActive || f) begin
         mErr  = mActive || !f;
         mMode = md;
         mAcc  = '0;
         mCnt  = 0;
         mOvf  = 0;
         mLock = 0;
      end else if (md != mMode) begin
         mErr = 1;
      end
      isUns = mMode[1];
      total = widen(128'(mAcc), ACC_W, isUns) + widen(128'(s), IN_W, isUns) + widen(128'(c), IN_W, isUns);
      if (isUns) over = (total > $signed(UMAX));
      else       over = (total > $signed(SMAX)) || (total < $signed(SMIN));
      if (over) mOvf = 1;
`ifdef PE_ACC_SAT_EN
      if (!mLock) begin
         if (over) begin
            mLock = 1;
            if (isUns)          mAcc = UMAX[ACC_W-1:0];
            else if (total < 0) mAcc = SMIN[ACC_W-1:0];
            else                mAcc = SMAX[ACC_W-1:0];
         end else begin
            mAcc = total[ACC_W-1:0];
         end
      end
`else
      mAcc = total[ACC_W-1:0];
`endif
      mCnt = (mCnt < 255) ? mCnt + 1 : 255;
      if (l) begin
         expValid = 1;
         expData  = mAcc;
         expCount = mCnt;
         expOvf   = mOvf;
         expErr   = mErr;
         mActive  = 0;
      end else begin
         mActive = 1;
      end
   endtask

   // One clock: drive inputs, check ready, advance the model, check registered outputs
   task automatic applyStimulus(input bit v, input logic [IN_W-1:0] s, input logic [IN_W-1:0] c,
                                input bit f, input bit l, input logic [1:0] md, input bit ordy);
      bit expReady;
      inValid  = v;
      inSum    = s;
      inCarry  = c;
      inFirst  = f;
      inLast   = l;
      inMode   = md;
      outReady = ordy;
      #1;
      expReady = !expValid || ordy;
      checkOutput("inReady", 128'(inReady), 128'(expReady));
      if (expValid && ordy) expValid = 0;
      if (v && expReady) modelBeat(s, c, f, l, md);
      @(posedge clk);
      #1;
      checkOutput("outValid", 128'(outValid), 128'(expValid));
      if (expValid) begin
         checkOutput("outData", 128'(outData), 128'(expData));
         checkOutput("outCount", 128'(outCount), 128'(expCount));
         checkOutput("outOvf", 128'(outOvf), 128'(expOvf));
         checkOutput("outErr", 128'(outErr), 128'(expErr));
      end
   endtask

   task automatic doReset();
      rst     = 1'b1;
      inValid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstValid", 128'(outValid), 128'd0);
      checkOutput("rstData", 128'(outData), 128'd0);
      checkOutput("rstCount", 128'(outCount), 128'd0);
      checkOutput("rstOvf", 128'(outOvf), 128'd0);
      checkOutput("rstErr", 128'(outErr), 128'd0);
      checkOutput("rstReady", 128'(inReady), 128'd1);
      rst      = 1'b0;
      mActive  = 0;
      mErr     = 0;
      mOvf     = 0;
      mLock    = 0;
      mCnt     = 0;
      mAcc     = '0;
      mMode    = '0;
      expValid = 0;
   endtask

   initial begin
      logic [IN_W-1:0]  negThree, big, bigPos;
      logic [ACC_W-1:0] expWrap;
      logic [1:0]       burstMode;
      bit               v, f, l, r;

      negThree = '0;
      negThree = negThree - IN_W'(3);
      bigPos   = {1'b0, {(IN_W-1){1'b1}}};

      @(posedge clk);
      #1;
      doReset();

      // Four signed beats of 10 + (-3)
      for (int i = 0; i < 4; i++) applyStimulus(1, IN_W'(10), negThree, i == 0, i == 3, 2'b00, 0);
      checkOutput("t1Data", 128'(outData), 128'd28);
      checkOutput("t1Count", 128'(outCount), 128'd4);

      // Unsigned single-beat burst, popped and refilled in the same cycle
      big = IN_W'(1) << 52;
      applyStimulus(1, big, IN_W'(1), 1, 1, 2'b10, 1);
      checkOutput("t2Data", 128'(outData), (128'd1 << 52) + 128'd1);
      checkOutput("t2Count", 128'(outCount), 128'd1);

      // Backpressure: consumer stalls while a new burst waits
      for (int i = 0; i < 5; i++) applyStimulus(1, IN_W'(5), IN_W'(6), 1, 1, 2'b00, 0);
      checkOutput("t3Held", 128'(outData), (128'd1 << 52) + 128'd1);
      applyStimulus(1, IN_W'(5), IN_W'(6), 1, 1, 2'b00, 1);
      checkOutput("t3Next", 128'(outData), 128'd11);

      // Signed overflow over 70 beats of 2*(2^108-1)
      for (int i = 0; i < 70; i++) applyStimulus(1, bigPos, bigPos, i == 0, i == 69, 2'b01, 1);
      checkOutput("t4Ovf", 128'(outOvf), 128'd1);
`ifdef PE_ACC_SAT_EN
      checkOutput("t4Sat", 128'(outData), SMAX);
`else
      expWrap = (ACC_W'(70) << 109) - ACC_W'(140);
      checkOutput("t4Wrap", 128'(outData), 128'(expWrap));
`endif

      // Restart mid-burst, then a headless burst from IDLE
      for (int i = 0; i < 3; i++) applyStimulus(1, IN_W'(1), IN_W'(1), i == 0, 0, 2'b00, 1);
      applyStimulus(1, IN_W'(7), IN_W'(0), 1, 1, 2'b00, 1);
      checkOutput("t5Err", 128'(outErr), 128'd1);
      checkOutput("t5Count", 128'(outCount), 128'd1);
      checkOutput("t5Data", 128'(outData), 128'd7);
      applyStimulus(1, IN_W'(2), IN_W'(2), 0, 1, 2'b00, 1);
      checkOutput("t5Idle", 128'(outErr), 128'd1);

      // Mode change inside a burst
      applyStimulus(1, IN_W'(1), IN_W'(1), 1, 0, 2'b00, 1);
      applyStimulus(1, IN_W'(1), IN_W'(1), 0, 1, 2'b10, 1);
      checkOutput("t5Mode", 128'(outErr), 128'd1);

      // Reset with a full buffer, then mid-burst
      doReset();
      applyStimulus(1, IN_W'(3), IN_W'(3), 1, 1, 2'b00, 0);
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1, IN_W'(9), IN_W'(9), i == 0, 0, 2'b00, 1);
      doReset();
      applyStimulus(1, IN_W'(4), IN_W'(0), 0, 1, 2'b00, 1);
      checkOutput("t6Drop", 128'(outData), 128'd4);

      // Long burst saturates the beat counter
      for (int i = 0; i < 300; i++) applyStimulus(1, IN_W'(1), IN_W'(0), i == 0, i == 299, 2'b00, 1);
      checkOutput("t6Count", 128'(outCount), 128'd255);
      checkOutput("t6Data", 128'(outData), 128'd300);

      // Random traffic with random backpressure and occasional protocol errors
      burstMode = 2'b00;
      for (int i = 0; i < 600; i++) begin
         v = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 5) == 0);
         l = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 2) != 0);
         if (f) burstMode = 2'($urandom_range(0, 3));
         applyStimulus(v, rand109(), rand109(), f, l,
                       ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : burstMode, r);
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
